dadz_pipe: RTL and testbench

- Pipelined, multi-lane activation-derivative unit for the backpropagation datapath.
- Takes a packed vector of LANES signed fixed-point activations and returns one derivative per lane. The derivative form is selected per beat.
- Computes in full precision, rounds and saturates the result, and moves data with a valid/ready handshake.
- Replaces the single-lane combinational derivative between the activation buffer and the delta/gradient multiplier array.

---
 rtl/dadz_pipe.sv | 136 +++++++++++++
 tb/tb_dadz_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dadz_pipe.sv
// Two-stage multi-lane activation-derivative unit: operand prep, then multiply/round/saturate.
// Uses a valid/ready handshake with a single global stall; tracks a saturation sticky flag and an output-beat counter.
module dadz_pipe #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned FRAC   = 24,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CWIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DWIDTH-1:0]   in_data,
  input  logic [1:0]                in_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DWIDTH-1:0]   out_data,
  output logic [LANES-1:0]          out_sat,
  output logic                      sat_sticky,
  input  logic                      clr,
  output logic [CWIDTH-1:0]         beat_cnt
);

  localparam int unsigned BW = DWIDTH + 1;
  localparam int unsigned PW = 2 * DWIDTH + 2;

  localparam logic signed [BW-1:0] ONE_B  = BW'(1) << FRAC;
  localparam logic signed [PW-1:0] ONE_P  = PW'(1) << FRAC;
  localparam logic signed [PW-1:0] HALF_P = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] SMAX_P = $signed({{(PW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}});
  localparam logic signed [PW-1:0] SMIN_P = $signed({{(PW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}});
  localparam logic [DWIDTH-1:0]    DMAX   = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0]    DMIN   = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_DSQ  = 2'd0,
    MODE_LOGI = 2'd1,
    MODE_TANH = 2'd2,
    MODE_PASS = 2'd3
  } mode_e;

  logic                     advance;
  logic                     s1_valid;
  mode_e                    s1_mode;
  logic signed [DWIDTH-1:0] s1_a [LANES];
  logic signed [BW-1:0]     s1_b [LANES];
  logic signed [DWIDTH-1:0] a_in [LANES];
  logic signed [BW-1:0]     b_nxt [LANES];
  logic signed [PW-1:0]     prod [LANES];
  logic signed [PW-1:0]     rnd [LANES];
  logic [LANES*DWIDTH-1:0]  nxt_data;
  logic [LANES-1:0]         nxt_sat;

  // Whole pipeline holds while the output beat is waiting.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Stage 1 operand: b = a-ONE, ONE-a or a, one bit wider so nothing wraps.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      a_in[i] = $signed(in_data[i*DWIDTH +: DWIDTH]);
      case (mode_e'(in_mode))
        MODE_DSQ:  b_nxt[i] = BW'(a_in[i]) - ONE_B;
        MODE_LOGI: b_nxt[i] = ONE_B - BW'(a_in[i]);
        default:   b_nxt[i] = BW'(a_in[i]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_DSQ;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_a[i] <= '0;
        s1_b[i] <= '0;
      end
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_mode  <= mode_e'(in_mode);
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_a[i] <= a_in[i];
        s1_b[i] <= b_nxt[i];
      end
    end
  end

  // Stage 2: full-precision product, round half-up, tanh complement, saturate.
  always_comb begin
    nxt_data = '0;
    nxt_sat  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod[i] = PW'(s1_a[i]) * PW'(s1_b[i]);
      rnd[i]  = (prod[i] + HALF_P) >>> FRAC;
      if (s1_mode == MODE_TANH) rnd[i] = ONE_P - rnd[i];
      if (s1_mode == MODE_PASS) begin
        nxt_data[i*DWIDTH +: DWIDTH] = s1_a[i];
      end else if (rnd[i] > SMAX_P) begin
        nxt_data[i*DWIDTH +: DWIDTH] = DMAX;
        nxt_sat[i] = 1'b1;
      end else if (rnd[i] < SMIN_P) begin
        nxt_data[i*DWIDTH +: DWIDTH] = DMIN;
        nxt_sat[i] = 1'b1;
      end else begin
        nxt_data[i*DWIDTH +: DWIDTH] = rnd[i][DWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_data  <= nxt_data;
      out_sat   <= nxt_sat & {LANES{s1_valid}};
    end
  end

  // Status: clr beats any same-cycle accept or saturation event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
      beat_cnt   <= '0;
    end else if (clr) begin
      sat_sticky <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      if (advance && s1_valid && (|nxt_sat)) sat_sticky <= 1'b1;
      if (out_valid && out_ready) beat_cnt <= beat_cnt + CWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dadz_pipe.sv
// Self-checking bench for dadz_pipe: directed mode/saturation/rounding/handshake steps plus a random stream,
// all scored against an arithmetic reference model and an in-order expectation queue.
module tb_dadz_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned LN = 4;
  localparam int unsigned LW = DW * LN;
  localparam longint      ONE = 64'sd1 << 24;

  typedef struct {
    logic [LW-1:0] data;
    logic [LN-1:0] sat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_data;
  logic [LN-1:0] out_sat;
  logic          sat_sticky;
  logic          clr;
  logic [15:0]   beat_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic front_shown = 1'b0;
  logic [15:0] cnt_m = '0;
  logic sticky_m = 1'b0;

  dadz_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .sat_sticky(sat_sticky), .clr(clr),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic longint floor_div(input longint x, input longint d);
    longint qv;
    qv = x / d;
    if ((x % d) != 0 && x < 0) qv = qv - 1;
    return qv;
  endfunction

  // Derivative of one lane from the mode formulas, with {sat, value} result.
  function automatic logic [DW:0] ref_lane(input logic [DW-1:0] araw, input logic [1:0] m);
    longint a, p, r;
    a = longint'($signed(araw));
    case (m)
      2'd0:    p = a * (a - ONE);
      2'd1:    p = a * (ONE - a);
      2'd2:    p = a * a;
      default: return {1'b0, araw};
    endcase
    r = floor_div(p + ONE / 2, ONE);
    if (m == 2'd2) r = ONE - r;
    if (r > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, r[DW-1:0]};
  endfunction

  function automatic exp_t ref_beat(input logic [LW-1:0] d, input logic [1:0] m);
    exp_t e;
    logic [DW:0] l;
    for (int i = 0; i < LN; i++) begin
      l = ref_lane(d[i*DW +: DW], m);
      e.data[i*DW +: DW] = l[DW-1:0];
      e.sat[i] = l[DW];
    end
    return e;
  endfunction

  // One clock: drive, score the output beat, then check status after the edge.
  task automatic tick(input logic v, input logic [LW-1:0] d, input logic [1:0] m,
                      input logic ordy, input logic c, output logic acc_in);
    logic adv, acc_out;
    @(negedge clk);
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; clr = c;
    #1;
    adv = !(out_valid && !ordy);
    check("in_ready", LW'(in_ready), LW'(adv));
    acc_in  = v && in_ready;
    acc_out = out_valid && ordy;
    if (out_valid) begin
      if (q.size() == 0) check("spurious_beat", LW'(1), LW'(0));
      else begin
        check("out_data", out_data, q[0].data);
        check("out_sat", LW'(out_sat), LW'(q[0].sat));
      end
    end
    if (acc_out && q.size() > 0) begin
      void'(q.pop_front());
      front_shown = 1'b0;
    end
    if (acc_in) q.push_back(ref_beat(d, m));
    @(posedge clk);
    #1;
    if (c) begin
      cnt_m = '0; sticky_m = 1'b0;
    end else if (acc_out) cnt_m = cnt_m + 16'd1;
    if (adv && out_valid && q.size() > 0 && !front_shown) begin
      front_shown = 1'b1;
      if (!c && (|q[0].sat)) sticky_m = 1'b1;
    end
    check("beat_cnt", LW'(beat_cnt), LW'(cnt_m));
    check("sat_sticky", LW'(sat_sticky), LW'(sticky_m));
  endtask

  function automatic logic [LW-1:0] pack(input logic [DW-1:0] lane0);
    logic [LW-1:0] d;
    for (int i = 0; i < LN; i++) d[i*DW +: DW] = DW'($urandom);
    d[DW-1:0] = lane0;
    return d;
  endfunction

  // Single beat into an empty pipe: verifies 2-edge latency and lane-0 golden value.
  task automatic send_one(input logic [DW-1:0] a, input logic [1:0] m,
                          input logic [DW-1:0] exp_v, input logic exp_s, input string tag);
    logic acc;
    tick(1'b1, pack(a), m, 1'b1, 1'b0, acc);
    check({tag, "_acc"}, LW'(acc), LW'(1));
    check({tag, "_lat1"}, LW'(out_valid), LW'(0));
    tick(1'b0, '0, 2'd0, 1'b1, 1'b0, acc);
    check({tag, "_lat2"}, LW'(out_valid), LW'(1));
    check({tag, "_val"}, LW'(out_data[DW-1:0]), LW'(exp_v));
    check({tag, "_sat"}, LW'(out_sat[0]), LW'(exp_s));
    tick(1'b0, '0, 2'd0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    int sent;
    logic [LW-1:0] d;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0; clr = 1'b0;
    #12;
    check("rst_out_valid", LW'(out_valid), LW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_sat", LW'(out_sat), LW'(0));
    check("rst_sticky", LW'(sat_sticky), LW'(0));
    check("rst_cnt", LW'(beat_cnt), LW'(0));
    check("rst_in_ready", LW'(in_ready), LW'(1));
    @(negedge clk); rst_n = 1'b1;

    send_one(32'h0080_0000, 2'd0, 32'hFFC0_0000, 1'b0, "m0_half");
    send_one(32'h0080_0000, 2'd1, 32'h0040_0000, 1'b0, "m1_half");
    send_one(32'h0080_0000, 2'd2, 32'h00C0_0000, 1'b0, "m2_half");
    send_one(32'h0080_0000, 2'd3, 32'h0080_0000, 1'b0, "m3_half");
    send_one(32'h6400_0000, 2'd0, 32'h7FFF_FFFF, 1'b1, "m0_sat");
    check("sticky_after_sat", LW'(sat_sticky), LW'(1));
    send_one(32'h6400_0000, 2'd1, 32'h8000_0000, 1'b1, "m1_sat");
    send_one(32'h6400_0000, 2'd2, 32'h8000_0000, 1'b1, "m2_sat");
    send_one(32'h8000_0000, 2'd0, 32'h7FFF_FFFF, 1'b1, "m0_min");
    send_one(32'h8000_0000, 2'd3, 32'h8000_0000, 1'b0, "m3_min");
    send_one(32'h0000_0001, 2'd1, 32'h0000_0001, 1'b0, "m1_lsb");
    send_one(32'h0000_0001, 2'd0, 32'hFFFF_FFFF, 1'b0, "m0_lsb");

    // Clear racing an accepted saturated beat.
    tick(1'b1, pack(32'h6400_0000), 2'd0, 1'b1, 1'b0, acc);
    tick(1'b0, '0, 2'd0, 1'b1, 1'b0, acc);
    check("race_pre_sticky", LW'(sat_sticky), LW'(1));
    tick(1'b0, '0, 2'd0, 1'b1, 1'b1, acc);
    check("race_cnt", LW'(beat_cnt), LW'(0));
    check("race_sticky", LW'(sat_sticky), LW'(0));

    // Back-pressure with out_ready 1,0,0 repeating.
    sent = 0;
    for (int k = 0; k < 100 && (sent < 8 || q.size() > 0); k++) begin
      tick(sent < 8, pack(DW'($urandom)), 2'(k % 4), (k % 3) == 0, 1'b0, acc);
      if (acc) sent++;
    end
    check("bp_sent", LW'(sent), LW'(8));
    check("bp_drained", LW'(q.size()), LW'(0));
    check("bp_cnt", LW'(beat_cnt), LW'(8));

    // Random stream with mixed magnitudes, stalls and occasional clears.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < LN; i++) begin
        case ($urandom_range(0, 3))
          0:       d[i*DW +: DW] = DW'($urandom);
          1:       d[i*DW +: DW] = DW'($urandom_range(0, 2 * 16777216)) - 32'h0100_0000;
          2:       d[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          default: d[i*DW +: DW] = DW'($urandom_range(0, 7)) - 32'd3;
        endcase
      end
      tick($urandom_range(0, 3) != 0, d, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, acc);
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) tick(1'b0, '0, 2'd0, 1'b1, 1'b0, acc);
    check("rand_drained", LW'(q.size()), LW'(0));

    // Asynchronous reset with two beats in flight.
    tick(1'b1, pack(32'h0080_0000), 2'd0, 1'b0, 1'b0, acc);
    tick(1'b1, pack(32'h6400_0000), 2'd0, 1'b0, 1'b0, acc);
    check("mid_valid_pre", LW'(out_valid), LW'(1));
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", LW'(out_valid), LW'(0));
    check("mid_cnt", LW'(beat_cnt), LW'(0));
    check("mid_sticky", LW'(sat_sticky), LW'(0));
    check("mid_out_data", out_data, '0);
    check("mid_in_ready", LW'(in_ready), LW'(1));
    q.delete(); front_shown = 1'b0; cnt_m = '0; sticky_m = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, '0, 2'd0, 1'b1, 1'b0, acc);
      check("post_rst_idle", LW'(out_valid), LW'(0));
    end
    send_one(32'h0080_0000, 2'd2, 32'h00C0_0000, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
